// File: rtl/msg_stream_pkg.sv
// -----------------------------------------------------------------------------
// msg_stream_pkg
// Shared definitions for the ASCII message streamer:
//   state_e   - streamer FSM state enumeration
//   ASCII_CR  - carriage return character (0x0D)
//   ASCII_LF  - line feed character (0x0A)
// -----------------------------------------------------------------------------
package msg_stream_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_WRITE,
        ST_CR,
        ST_LF,
        ST_DONE
    } state_e;

    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;

endpackage

// File: rtl/msg_index_counter.sv
// -----------------------------------------------------------------------------
// msg_index_counter
// IDX_W-bit character index with synchronous clear and count enable, plus a
// terminal compare against the latched last-character index.
// Ports:
//   clk_i   - clock
//   rst_i   - synchronous active-high reset
//   clr_i   - synchronous clear to zero
//   en_i    - increment by one (ignored while clr_i is high)
//   last_i  - index of the last character
//   idx_o   - current index
//   term_o  - high when idx_o equals last_i
// -----------------------------------------------------------------------------
module msg_index_counter #(
    parameter int IDX_W = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic [IDX_W-1:0] last_i,
    output logic [IDX_W-1:0] idx_o,
    output logic             term_o
);

    logic [IDX_W-1:0] cnt_q;
    logic [IDX_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + IDX_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign idx_o  = cnt_q;
    assign term_o = (cnt_q == last_i);

endmodule

// File: rtl/ascii_msg_streamer.sv
// -----------------------------------------------------------------------------
// ascii_msg_streamer
// Streams a message of msg_last+1 characters from a synchronous ROM (1-cycle
// read latency) into a TX FIFO, one character every FETCH/WRITE pair, holding
// the write while the FIFO is full.
// Build option: define MSG_CRLF_EN to append CR (0x0D) and LF (0x0A) after the
// last character.
// Ports:
//   clk       - clock
//   reset     - synchronous active-high reset
//   start     - stream request, sampled only while idle
//   abort     - terminate current message, no further writes, no done
//   msg_last  - index of last character, latched on accepted start
//   rom_addr  - ROM character address
//   rom_data  - ROM read data (valid one cycle after rom_addr)
//   fifo_full - TX FIFO full, holds the pending write
//   wr_en     - TX FIFO write strobe
//   wr_data   - character written (zero when wr_en is low)
//   busy      - high in every state except idle
//   done      - one-cycle pulse on normal completion
// -----------------------------------------------------------------------------
module ascii_msg_streamer
    import msg_stream_pkg::*;
#(
    parameter int IDX_W  = 4,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [IDX_W-1:0]  msg_last,
    output logic [IDX_W-1:0]  rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    input  logic              fifo_full,
    output logic              wr_en,
    output logic [DATA_W-1:0] wr_data,
    output logic              busy,
    output logic              done
);

    state_e           state_q, state_d;
    logic [IDX_W-1:0] last_q, last_d;
    logic [IDX_W-1:0] idx;
    logic             idx_term;
    logic             cnt_clr;
    logic             cnt_en;
    logic             wr_en_d;
    logic [DATA_W-1:0] wr_data_d;
    logic             done_d;

    msg_index_counter #(
        .IDX_W (IDX_W)
    ) u_idx (
        .clk_i  (clk),
        .rst_i  (reset),
        .clr_i  (cnt_clr),
        .en_i   (cnt_en),
        .last_i (last_q),
        .idx_o  (idx),
        .term_o (idx_term)
    );

    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        cnt_en    = 1'b0;
        wr_en_d   = 1'b0;
        wr_data_d = '0;
        done_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start && !abort) begin
                    last_d  = msg_last;
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                state_d = ST_WRITE;
            end
            ST_WRITE: begin
                if (!fifo_full) begin
                    wr_en_d   = 1'b1;
                    wr_data_d = rom_data;
                    if (idx_term) begin
`ifdef MSG_CRLF_EN
                        state_d = ST_CR;
`else
                        state_d = ST_DONE;
`endif
                    end else begin
                        cnt_en  = 1'b1;
                        state_d = ST_FETCH;
                    end
                end
            end
`ifdef MSG_CRLF_EN
            ST_CR: begin
                if (!fifo_full) begin
                    wr_en_d   = 1'b1;
                    wr_data_d = DATA_W'(ASCII_CR);
                    state_d   = ST_LF;
                end
            end
            ST_LF: begin
                if (!fifo_full) begin
                    wr_en_d   = 1'b1;
                    wr_data_d = DATA_W'(ASCII_LF);
                    state_d   = ST_DONE;
                end
            end
`endif
            ST_DONE: begin
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Abort overrides whatever the active state decided this cycle.
        if (abort && (state_q != ST_IDLE)) begin
            state_d   = ST_IDLE;
            cnt_en    = 1'b0;
            wr_en_d   = 1'b0;
            wr_data_d = '0;
            done_d    = 1'b0;
        end
    end

    // Index is zero whenever the FSM sits in (or returns to) idle.
    assign cnt_clr = (state_d == ST_IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            last_q  <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
        end
    end

    assign rom_addr = idx;
    assign wr_en    = wr_en_d;
    assign wr_data  = wr_data_d;
    assign done     = done_d;
    assign busy     = (state_q != ST_IDLE);

endmodule
